// File: rtl/conv5x5_layer3_if.sv
// Bus bundle for conv5x5_layer3: start/bias control, map and weight read
// ports, output BRAM write port and status.
interface conv5x5_layer3_if #(
  parameter int DATA_W = 12,
  parameter int WGT_W  = 8,
  parameter int BIAS_W = 16
);
  logic                     start;
  logic signed [BIAS_W-1:0] bias;
  logic [7:0]               map_addr;
  logic [DATA_W-1:0]        map_dout;
  logic [4:0]               w_addr;
  logic signed [WGT_W-1:0]  w_dout;
  logic [6:0]               out_addr;
  logic [DATA_W-1:0]        out_din;
  logic                     out_wea;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, bias, map_dout, w_dout,
    output map_addr, w_addr, out_addr, out_din, out_wea, busy, done
  );

  modport slave (
    output start, bias, map_dout, w_dout,
    input  map_addr, w_addr, out_addr, out_din, out_wea, busy, done
  );
endinterface

// File: rtl/conv5x5_layer3.sv
// Sequential single-MAC 5x5 convolution of the 14x14 pooled map into a 10x10 map.
// Macro CONV_RELU_EN selects ReLU/unsigned saturation; default is signed saturation.
module conv5x5_layer3 #(
  parameter int MAP_W  = 14,
  parameter int K      = 5,
  parameter int OUT_W  = 10,
  parameter int DATA_W = 12,
  parameter int WGT_W  = 8,
  parameter int BIAS_W = 16,
  parameter int ACC_W  = 28,
  parameter int SHIFT  = 6
) (
  input logic clk,
  input logic rst,
  conv5x5_layer3_if.master bus
);

  localparam int PROD_W = DATA_W + 1 + WGT_W;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FIN} state_t;

  state_t                   state_r, state_nxt_s;
  logic [2:0]               kx_r, ky_r, kx_nxt_s, ky_nxt_s;
  logic [3:0]               ox_r, oy_r, ox_nxt_s, oy_nxt_s;
  logic                     mac_vld_r, mac_first_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [BIAS_W-1:0] bias_r;
  logic [7:0]               map_addr_r, map_addr_s;
  logic [4:0]               w_addr_r, w_addr_s;
  logic [6:0]               out_addr_r;
  logic [DATA_W-1:0]        out_din_r;
  logic                     out_wea_r, busy_r, done_r;

  logic signed [DATA_W:0]   mdat_s;
  logic signed [WGT_W-1:0]  wdat_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s, acc_base_s, sum_s, bias_ext_s, r_s;

  // Saturate the shifted result to the output pixel format.
  function automatic logic [DATA_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] r);
`ifdef CONV_RELU_EN
    if (r < $signed({ACC_W{1'b0}})) begin
      clamp_pix = {DATA_W{1'b0}};
    end else if (r > $signed(ACC_W'((1 << DATA_W) - 1))) begin
      clamp_pix = {DATA_W{1'b1}};
    end else begin
      clamp_pix = r[DATA_W-1:0];
    end
`else
    if (r < -$signed(ACC_W'(1 << (DATA_W - 1)))) begin
      clamp_pix = {1'b1, {(DATA_W-1){1'b0}}};
    end else if (r > $signed(ACC_W'((1 << (DATA_W - 1)) - 1))) begin
      clamp_pix = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      clamp_pix = r[DATA_W-1:0];
    end
`endif
  endfunction

  // Next-state, counter advance and next read addresses.
  always_comb begin
    state_nxt_s = state_r;
    kx_nxt_s    = kx_r;
    ky_nxt_s    = ky_r;
    ox_nxt_s    = ox_r;
    oy_nxt_s    = oy_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = FETCH;
          kx_nxt_s    = 3'd0;
          ky_nxt_s    = 3'd0;
          ox_nxt_s    = 4'd0;
          oy_nxt_s    = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (kx_r == 3'(K - 1)) begin
          kx_nxt_s = 3'd0;
          if (ky_r == 3'(K - 1)) begin
            ky_nxt_s    = 3'd0;
            state_nxt_s = DRAIN;
          end else begin
            ky_nxt_s = ky_r + 3'd1;
          end
        end else begin
          kx_nxt_s = kx_r + 3'd1;
        end
      end
      DRAIN: state_nxt_s = WRITE;
      WRITE: begin
        state_nxt_s = FETCH;
        if (ox_r == 4'(OUT_W - 1)) begin
          ox_nxt_s = 4'd0;
          if (oy_r == 4'(OUT_W - 1)) begin
            oy_nxt_s    = 4'd0;
            state_nxt_s = FIN;
          end else begin
            oy_nxt_s = oy_r + 4'd1;
          end
        end else begin
          ox_nxt_s = ox_r + 4'd1;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    map_addr_s = 8'(ox_nxt_s) + 8'(kx_nxt_s) + 8'(MAP_W) * (8'(oy_nxt_s) + 8'(ky_nxt_s));
    w_addr_s   = 5'(kx_nxt_s) + 5'(K) * 5'(ky_nxt_s);
  end

  // MAC datapath: map data is unsigned, so it gets a zero sign bit before the multiply.
  always_comb begin
    mdat_s     = $signed({1'b0, bus.map_dout});
    wdat_s     = bus.w_dout;
    prod_s     = mdat_s * wdat_s;
    prod_ext_s = prod_s;
    if (mac_first_r) begin
      acc_base_s = {ACC_W{1'b0}};
    end else begin
      acc_base_s = acc_r;
    end
    sum_s      = acc_base_s + prod_ext_s;
    bias_ext_s = bias_r;
    r_s        = (sum_s + bias_ext_s) >>> SHIFT;
  end

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      kx_r        <= 3'd0;
      ky_r        <= 3'd0;
      ox_r        <= 4'd0;
      oy_r        <= 4'd0;
      mac_vld_r   <= 1'b0;
      mac_first_r <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      bias_r      <= {BIAS_W{1'b0}};
      map_addr_r  <= 8'd0;
      w_addr_r    <= 5'd0;
      out_addr_r  <= 7'd0;
      out_din_r   <= {DATA_W{1'b0}};
      out_wea_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      kx_r        <= kx_nxt_s;
      ky_r        <= ky_nxt_s;
      ox_r        <= ox_nxt_s;
      oy_r        <= oy_nxt_s;
      mac_vld_r   <= (state_r == FETCH);
      mac_first_r <= (state_r == FETCH) && (kx_r == 3'd0) && (ky_r == 3'd0);
      if (mac_vld_r) begin
        acc_r <= sum_s;
      end
      if ((state_r == IDLE) && bus.start) begin
        bias_r <= bus.bias;
      end
      if (state_nxt_s == FETCH) begin
        map_addr_r <= map_addr_s;
        w_addr_r   <= w_addr_s;
      end
      if (state_r == DRAIN) begin
        out_din_r <= clamp_pix(r_s);
      end
      if (state_nxt_s == WRITE) begin
        out_addr_r <= 7'(ox_r) + 7'(OUT_W) * 7'(oy_r);
      end
      out_wea_r <= (state_nxt_s == WRITE);
      busy_r    <= (state_nxt_s == FETCH) || (state_nxt_s == DRAIN) || (state_nxt_s == WRITE);
      done_r    <= (state_nxt_s == FIN);
    end
  end

  assign bus.map_addr = map_addr_r;
  assign bus.w_addr   = w_addr_r;
  assign bus.out_addr = out_addr_r;
  assign bus.out_din  = out_din_r;
  assign bus.out_wea  = out_wea_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_conv5x5_layer3.sv
// Scoreboard bench for conv5x5_layer3: two instances (SHIFT=0 and SHIFT=6) share
// behavioural map/weight memories; expected pixels are queued at start and popped on writes.
module tb_conv5x5_layer3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv5x5_layer3_if if0 ();
  conv5x5_layer3_if if6 ();

  conv5x5_layer3 #(.SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  conv5x5_layer3 #(.SHIFT(6)) u_dut6 (.clk(clk), .rst(rst), .bus(if6.master));

  logic [11:0]       map_mem [196];
  logic signed [7:0] w_mem   [25];

  // Synchronous-read memory models, one read port per instance.
  always @(posedge clk) begin
    if0.map_dout <= map_mem[if0.map_addr];
    if0.w_dout   <= w_mem[if0.w_addr];
    if6.map_dout <= map_mem[if6.map_addr];
    if6.w_dout   <= w_mem[if6.w_addr];
  end

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int exp_pix(input int ox, input int oy, input int b, input int shift);
    int acc;
    int r;
    acc = 0;
    for (int ky = 0; ky < 5; ky++) begin
      for (int kx = 0; kx < 5; kx++) begin
        acc += int'(map_mem[(ox + kx) + 14 * (oy + ky)]) * int'(w_mem[kx + 5 * ky]);
      end
    end
    r = (acc + b) >>> shift;
`ifdef CONV_RELU_EN
    if (r < 0) return 0;
    if (r > 4095) return 4095;
    return r;
`else
    if (r < -2048) return 32'h800;
    if (r > 2047) return 32'h7FF;
    return r & 32'hFFF;
`endif
  endfunction

  task automatic run_pass(input string name, input int sel, input int b, input int abort_at,
                          input int restart_at);
    int   shift;
    int   n_wea, n_done, first_wea, last_wea, done_cyc, late_evt;
    logic wea, busy, done;
    logic [6:0]  addr;
    logic [11:0] din;
    exp_t e;
    shift = (sel != 0) ? 6 : 0;
    sb_q.delete();
    for (int oy = 0; oy < 10; oy++) begin
      for (int ox = 0; ox < 10; ox++) begin
        e.addr = ox + 10 * oy;
        e.data = exp_pix(ox, oy, b, shift);
        sb_q.push_back(e);
      end
    end
    n_wea = 0; n_done = 0; first_wea = -1; last_wea = -1; done_cyc = -1; late_evt = 0;
    @(negedge clk);
    if (sel != 0) begin if6.start = 1'b1; if6.bias = 16'(b); end
    else begin if0.start = 1'b1; if0.bias = 16'(b); end
    for (int c = 1; c <= 2800; c++) begin
      @(negedge clk);
      if0.start = (sel == 0) && (c == restart_at);
      if6.start = (sel != 0) && (c == restart_at);
      if0.bias  = 16'($urandom);
      if6.bias  = 16'($urandom);
      wea  = (sel != 0) ? if6.out_wea  : if0.out_wea;
      busy = (sel != 0) ? if6.busy     : if0.busy;
      done = (sel != 0) ? if6.done     : if0.done;
      addr = (sel != 0) ? if6.out_addr : if0.out_addr;
      din  = (sel != 0) ? if6.out_din  : if0.out_din;
      if (c == 1) check_val({name, "_busy_c1"}, 32'(busy), 32'd1);
      if (abort_at != 0 && c == abort_at) rst = 1'b1;
      if (abort_at != 0 && c == abort_at + 1) begin
        check_val({name, "_wea_after_rst"}, 32'(wea), 32'd0);
        check_val({name, "_busy_after_rst"}, 32'(busy), 32'd0);
        rst = 1'b0;
      end
      if (abort_at != 0 && c > abort_at && (wea || done)) late_evt++;
      if (wea) begin
        n_wea++;
        if (first_wea < 0) first_wea = c;
        last_wea = c;
        if (sb_q.size() == 0) begin
          check_val({name, "_extra_write"}, 32'(n_wea), 32'd100);
        end else begin
          e = sb_q.pop_front();
          check_val({name, "_addr"}, 32'(addr), 32'(e.addr));
          check_val({name, "_data"}, 32'(din), 32'(e.data));
        end
      end
      if (done) begin
        n_done++;
        done_cyc = c;
        check_val({name, "_busy_at_done"}, 32'(busy), 32'd0);
      end
      if (abort_at != 0 && c >= abort_at + 100) break;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    if (abort_at != 0) begin
      check_val({name, "_writes_before_rst"}, 32'(n_wea), 32'(abort_at / 27));
      check_val({name, "_events_after_rst"}, 32'(late_evt), 32'd0);
      check_val({name, "_done_count"}, 32'(n_done), 32'd0);
      sb_q.delete();
    end else begin
      check_val({name, "_write_count"}, 32'(n_wea), 32'd100);
      check_val({name, "_done_count"}, 32'(n_done), 32'd1);
      check_val({name, "_first_wea_cyc"}, 32'(first_wea), 32'd27);
      check_val({name, "_last_wea_cyc"}, 32'(last_wea), 32'd2700);
      check_val({name, "_done_cyc"}, 32'(done_cyc), 32'd2701);
      check_val({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.bias = '0;
    if6.start = 1'b0; if6.bias = '0;
    for (int i = 0; i < 196; i++) map_mem[i] = 12'd0;
    for (int i = 0; i < 25; i++) w_mem[i] = 8'sd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_wea0", 32'(if0.out_wea), 32'd0);
    check_val("rst_busy0", 32'(if0.busy), 32'd0);
    check_val("rst_done0", 32'(if0.done), 32'd0);
    check_val("rst_oaddr0", 32'(if0.out_addr), 32'd0);
    check_val("rst_odin0", 32'(if0.out_din), 32'd0);
    check_val("rst_maddr0", 32'(if0.map_addr), 32'd0);
    check_val("rst_waddr0", 32'(if0.w_addr), 32'd0);
    check_val("rst_wea6", 32'(if6.out_wea), 32'd0);
    check_val("rst_busy6", 32'(if6.busy), 32'd0);
    check_val("rst_done6", 32'(if6.done), 32'd0);
    check_val("rst_odin6", 32'(if6.out_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'd1;
    for (int i = 0; i < 25; i++) w_mem[i] = 8'sd1;
    run_pass("ones", 0, 0, 0, 0);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'(i);
    for (int i = 0; i < 25; i++) w_mem[i] = (i == 12) ? 8'sd1 : 8'sd0;
    run_pass("center_tap", 0, 0, 0, 0);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'd4095;
    for (int i = 0; i < 25; i++) w_mem[i] = 8'sd127;
    run_pass("sat_high", 0, 0, 0, 0);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'd10;
    for (int i = 0; i < 25; i++) w_mem[i] = -8'sd1;
    run_pass("negative", 0, 0, 0, 0);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'd0;
    run_pass("bias_pos", 1, 640, 0, 0);
    run_pass("bias_neg", 1, -65, 0, 0);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 25; i++) w_mem[i] = 8'($urandom);
    run_pass("random_s6", 1, int'($urandom_range(0, 65535)) - 32768, 0, 0);

    for (int i = 0; i < 196; i++) map_mem[i] = 12'($urandom_range(0, 60));
    for (int i = 0; i < 25; i++) w_mem[i] = 8'($urandom_range(0, 6)) - 8'sd3;
    run_pass("abort", 0, 5, 500, 0);
    run_pass("restart", 0, -7, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
